flp_to_int_wrapper: RTL and testbench
=====================================

FLP_TO_INT_WRAPPER -- requirements
Module: flp_to_int_wrapper

Interface
REQ-001 SHALL have parameter LOGN, default 13, meaning log2 of coefficient count N.
REQ-002 SHALL have parameter LOGQ, default 54, meaning width of modulus and integer coefficients.
REQ-003 SHALL have parameter EXP_BITS, default 11, meaning floating-point exponent width (bias 2^(EXP_BITS-1)-1).
REQ-004 SHALL have parameter MANT_BITS, default 52, meaning stored mantissa width; FW = 1+EXP_BITS+MANT_BITS; word = {sign, exp, mant}.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle request to begin a sweep.
REQ-008 SHALL have port q, input, LOGQ, modulus; held stable while busy.
REQ-009 SHALL have port scale_power, input, EXP_BITS+1, unsigned scaling exponent; held stable while busy.
REQ-010 SHALL have port bram_rd_addr, output, LOGN-1, complex-entry read address.
REQ-011 SHALL have port bram_rd_data, input, 2*FW, {real, imag}, valid 2 cycles after address.
REQ-012 SHALL have ports bram_wr_addr, output, LOGN; bram_wr_data, output, LOGQ; bram_wea, output, 1.
REQ-013 SHALL have ports busy, output, 1; done, output, 1 (one-cycle pulse); overflow, output, 1 (sticky per sweep).

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start; READ->DRAIN after issuing read address 2^(LOGN-1)-1; DRAIN->IDLE after the last write.
REQ-015 SHALL ignore start while busy; busy SHALL be high in READ and DRAIN.
REQ-016 SHALL issue read address j (0..2^(LOGN-1)-1) every second cycle; first address issued the cycle after start is sampled.
REQ-017 SHALL register each read entry and feed real then imag through one shared converter with latency 3 cycles.
REQ-018 SHALL write real result of entry j to address j and imag result to address j+2^(LOGN-1), on consecutive cycles.
REQ-019 With start sampled at cycle 0: real write of entry 0 SHALL occur at cycle 6; writes SHALL be contiguous through cycle 6+N-1; done SHALL pulse at cycle 6+N, coincident with busy falling.
REQ-020 Conversion: shift = exp - bias + scale_power (signed); exp==0 SHALL yield 0; shift < -1 SHALL yield 0.
REQ-021 Otherwise mag = round({1,mant} * 2^(shift-MANT_BITS)), round half away from zero.
REQ-022 If shift >= LOGQ-1 or mag >= q: output 0 and set overflow; exp all-ones (Inf/NaN) SHALL be treated as overflow.
REQ-023 Result SHALL be q-mag when sign=1 and mag!=0, else mag (negative zero yields 0).
REQ-024 overflow SHALL clear when a new sweep starts and hold its value after done until next start.
REQ-025 bram_wea SHALL be high only on the N write cycles of a sweep.

Reset
REQ-026 On rst: state IDLE, busy=0, done=0, bram_wea=0, overflow=0, bram_rd_addr=0, bram_wr_addr=0, bram_wr_data=0, all pipeline valids cleared.
REQ-027 rst mid-sweep SHALL abort with no further writes from the cycle after rst is sampled; no done pulse for the aborted sweep.
REQ-028 rst asserted together with start SHALL take priority; block remains IDLE.

Verification (LOGN=4, LOGQ=54, q=2^53-2^23+1 unless stated)
REQ-029 Entry0 real=0x3FF0000000000000 (1.0), imag=0xBFF0000000000000 (-1.0), scale_power=10 -> addr0=1024, addr8=q-1024.
REQ-030 Entry1 real=0.5, imag=-0.5, scale_power=0 -> addr1=1, addr9=q-1; 0.25 -> 0; 1.5 -> 2.
REQ-031 Entry2 real=+0.0, imag=2^-60, scale_power=0 -> addr2=0, addr10=0, overflow=0.
REQ-032 Entry3 real=2^60, scale_power=0 -> addr3=0, overflow=1 after done; next sweep with clean data -> overflow=0.
REQ-033 start at cycle 0 -> wea high cycles 6..21 with addresses 0,8,1,9,...,7,15; done pulse cycle 22; start at cycle 5 ignored.
REQ-034 rst at cycle 10 of a sweep -> wea low from cycle 11, busy=0, no done; new start after reset completes a full correct sweep.

Source files
------------

// File: rtl/flp_to_int_wrapper.sv
// Sweeps N/2 complex floating-point entries out of a read BRAM, converts real and imag
// parts to signed integers mod q, and writes the N results to a write BRAM.
module flp_to_int_wrapper #(
  parameter int LOGN      = 13,
  parameter int LOGQ      = 54,
  parameter int EXP_BITS  = 11,
  parameter int MANT_BITS = 52
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [LOGQ-1:0]                      q,
  input  logic [EXP_BITS:0]                    scale_power,
  output logic [LOGN-2:0]                      bram_rd_addr,
  input  logic [2*(1+EXP_BITS+MANT_BITS)-1:0]  bram_rd_data,
  output logic [LOGN-1:0]                      bram_wr_addr,
  output logic [LOGQ-1:0]                      bram_wr_data,
  output logic                                 bram_wea,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing one read address every second cycle
  // DRAIN | reads finished, converter pipeline still writing results

  localparam int FW   = 1 + EXP_BITS + MANT_BITS;
  localparam int SW   = EXP_BITS + 3;
  localparam int WX   = MANT_BITS + 2 + LOGQ;
  localparam int BIAS = 2**(EXP_BITS-1) - 1;

  localparam logic signed [SW-1:0] BIAS_S    = SW'(BIAS);
  localparam logic signed [SW-1:0] SHIFT_MIN = SW'(-1);
  localparam logic signed [SW-1:0] SHIFT_OVF = SW'(LOGQ - 1);
  localparam logic signed [SW-1:0] RSH_BASE  = SW'(MANT_BITS + LOGQ);
  localparam logic [WX-1:0]        WX_ONE    = WX'(1);
  localparam logic [LOGN-2:0]      RD_LAST   = {(LOGN-1){1'b1}};
  localparam logic [LOGN-1:0]      WR_LAST   = {LOGN{1'b1}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_nxt;
  logic   sweep_start, rd_issue, rd_phase;
  logic   rd_v1, rd_v2, cv_re, cv_im;
  logic [FW-1:0]   ent_re, ent_im;
  logic [LOGN-1:0] wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (rd_phase && bram_rd_addr == RD_LAST) state_nxt = DRAIN;
      DRAIN:   if (bram_wea && bram_wr_addr == WR_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    sweep_start = (state == IDLE) && start;
    rd_issue    = (state == READ) && !rd_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bram_rd_addr <= '0;
      rd_phase     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == DRAIN) && (state_nxt == IDLE);
      if (sweep_start) begin
        bram_rd_addr <= '0;
        rd_phase     <= 1'b0;
      end else if (state == READ) begin
        rd_phase <= ~rd_phase;
        if (rd_phase && bram_rd_addr != RD_LAST) bram_rd_addr <= bram_rd_addr + (LOGN-1)'(1);
      end
    end
  end

  // Read data lands two cycles after the address; real goes in first, imag the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      cv_re <= 1'b0;
      cv_im <= 1'b0;
    end else begin
      rd_v1 <= rd_issue;
      rd_v2 <= rd_v1;
      cv_re <= rd_v2;
      cv_im <= cv_re;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_v2) begin
      ent_re <= bram_rd_data[2*FW-1:FW];
      ent_im <= bram_rd_data[FW-1:0];
    end
  end

  logic [FW-1:0]        in_word;
  logic                 in_valid, in_sign, exp_zero, exp_max;
  logic [EXP_BITS-1:0]  in_exp;
  logic signed [SW-1:0] in_shift;
  logic [SW-1:0]        in_rsh;

  always_comb begin
    in_word  = cv_re ? ent_re : ent_im;
    in_valid = cv_re | cv_im;
    in_sign  = in_word[FW-1];
    in_exp   = in_word[FW-2 -: EXP_BITS];
    exp_zero = (in_exp == '0);
    exp_max  = &in_exp;
    in_shift = $signed({3'b000, in_exp}) - BIAS_S + $signed({2'b00, scale_power});
    in_rsh   = RSH_BASE - in_shift;
  end

  logic                 s1_v, s1_sign, s1_zero, s1_ovf;
  logic [MANT_BITS:0]   s1_sig;
  logic [SW-1:0]        s1_rsh;

  always_ff @(posedge clk) begin
    if (rst) s1_v <= 1'b0;
    else     s1_v <= in_valid;
    s1_sign <= in_sign;
    s1_zero <= exp_zero || (!exp_max && in_shift < SHIFT_MIN);
    s1_ovf  <= !exp_zero && (exp_max || in_shift >= SHIFT_OVF);
    s1_sig  <= {1'b1, in_word[MANT_BITS-1:0]};
    s1_rsh  <= in_rsh;
  end

  // Significand is pre-scaled by 2^LOGQ so every legal shift becomes a right shift;
  // adding half an output LSB before truncating rounds half away from zero.
  logic [WX-1:0] s1_x, s1_half, s1_rounded;

  always_comb begin
    s1_x       = {1'b0, s1_sig, {LOGQ{1'b0}}};
    s1_half    = WX_ONE << (s1_rsh - SW'(1));
    s1_rounded = (s1_x + s1_half) >> s1_rsh;
  end

  logic            s2_v, s2_sign, s2_zero, s2_ovf;
  logic [LOGQ-1:0] s2_mag;

  always_ff @(posedge clk) begin
    if (rst) s2_v <= 1'b0;
    else     s2_v <= s1_v;
    s2_sign <= s1_sign;
    s2_zero <= s1_zero;
    s2_ovf  <= s1_ovf || (|s1_rounded[WX-1:LOGQ]);
    s2_mag  <= s1_rounded[LOGQ-1:0];
  end

  logic            res_ovf;
  logic [LOGQ-1:0] res_val;

  always_comb begin
    res_ovf = !s2_zero && (s2_ovf || s2_mag >= q);
    if (s2_zero || res_ovf)         res_val = '0;
    else if (s2_sign && s2_mag != 0) res_val = q - s2_mag;
    else                             res_val = s2_mag;
  end

  // Writes alternate real/imag, so the count's LSB selects the upper half of the address space.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_wea     <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      wr_cnt       <= '0;
      overflow     <= 1'b0;
    end else begin
      bram_wea <= s2_v;
      if (s2_v) begin
        bram_wr_addr <= {wr_cnt[0], wr_cnt[LOGN-1:1]};
        bram_wr_data <= res_val;
        wr_cnt       <= wr_cnt + LOGN'(1);
        if (res_ovf) overflow <= 1'b1;
      end
      if (sweep_start) begin
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flp_to_int_wrapper.sv
// Randomized and directed bench for flp_to_int_wrapper with N=16 against an arithmetic reference model.
module tb_flp_to_int_wrapper;
  localparam int LOGN = 4;
  localparam int LOGQ = 54;
  localparam int NE   = 8;
  localparam int NCYC = 30;
  localparam logic [53:0] Q_STD = 54'h20000000000000 - 54'h800000 + 54'd1;

  localparam logic [63:0] F_ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] F_MONE  = 64'hBFF0000000000000;
  localparam logic [63:0] F_HALF  = 64'h3FE0000000000000;
  localparam logic [63:0] F_MHALF = 64'hBFE0000000000000;
  localparam logic [63:0] F_QTR   = 64'h3FD0000000000000;
  localparam logic [63:0] F_1P5   = 64'h3FF8000000000000;
  localparam logic [63:0] F_PZ    = 64'h0000000000000000;
  localparam logic [63:0] F_NZ    = 64'h8000000000000000;
  localparam logic [63:0] F_TINY  = 64'h3C30000000000000;
  localparam logic [63:0] F_BIG   = 64'h43B0000000000000;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [53:0]  q;
  logic [11:0]  scale_power;
  logic [2:0]   bram_rd_addr;
  logic [127:0] bram_rd_data;
  logic [3:0]   bram_wr_addr;
  logic [53:0]  bram_wr_data;
  logic         bram_wea, busy, done, overflow;

  flp_to_int_wrapper #(.LOGN(LOGN), .LOGQ(LOGQ), .EXP_BITS(11), .MANT_BITS(52)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .scale_power(scale_power),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data), .bram_wea(bram_wea),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [NE];
  logic [127:0] mem_q1, mem_q2;
  always @(posedge clk) begin
    mem_q1 <= mem[bram_rd_addr];
    mem_q2 <= mem_q1;
  end
  assign bram_rd_data = mem_q2;

  int checks = 0;
  int failures = 0;

  logic        wea_log  [NCYC];
  logic        busy_log [NCYC];
  logic        done_log [NCYC];
  logic        ovf_log  [NCYC];
  logic [3:0]  waddr_log[NCYC];
  logic [53:0] wdata_log[NCYC];
  logic [2:0]  raddr_log[NCYC];

  // Returns {overflow, value}: value = round(float * 2^sp) reduced to the mod-q representation.
  function automatic logic [54:0] model_conv(input logic [63:0] w, input int sp, input logic [53:0] qv);
    logic [10:0]  e;
    int           sh, r;
    logic [127:0] sig, mag, rem, unit;
    e = w[62:52];
    if (e == 11'd0) return 55'd0;
    if (e == 11'h7FF) return {1'b1, 54'd0};
    sh = int'(e) - 1023 + sp;
    if (sh < -1) return 55'd0;
    if (sh >= 53) return {1'b1, 54'd0};
    sig = {75'd0, 1'b1, w[51:0]};
    if (sh >= 52) begin
      mag = sig << (sh - 52);
    end else begin
      r    = 52 - sh;
      unit = 128'd1 << r;
      mag  = sig / unit;
      rem  = sig % unit;
      if (rem * 2 >= unit) mag = mag + 1;
    end
    if (mag >= {74'd0, qv}) return {1'b1, 54'd0};
    if (w[63] && mag != 0) return {1'b0, qv - mag[53:0]};
    return {1'b0, mag[53:0]};
  endfunction

  function automatic logic [63:0] rand_word(input bit wild);
    logic [51:0] mant;
    logic [10:0] e;
    logic        sgn;
    int          off, pick;
    mant = 52'({$urandom, $urandom});
    sgn  = 1'($urandom_range(0, 1));
    pick = int'($urandom_range(0, 15));
    if (wild) off = int'($urandom_range(0, 125)) - 70;
    else      off = int'($urandom_range(0, 45)) - 5;
    e = 11'(1023 + off);
    if (wild && pick == 0) e = 11'd0;
    if (wild && pick == 1) e = 11'h7FF;
    return {sgn, e, mant};
  endfunction

  task automatic fill_random(input bit wild);
    for (int i = 0; i < NE; i++) mem[i] = {rand_word(wild), rand_word(wild)};
  endtask

  // Start sampled at edge 0; logs cycle k as seen after edge k. Optional rst at cycle
  // rst_cyc (sampled at edge rst_cyc+1) and optional extra start sampled at edge 5.
  task automatic run_sweep(input int rst_cyc, input bit dup_start);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start = dup_start && (k == 4);
      rst   = (k == rst_cyc);
      @(negedge clk);
      wea_log[k]   = bram_wea;
      busy_log[k]  = busy;
      done_log[k]  = done;
      ovf_log[k]   = overflow;
      waddr_log[k] = bram_wr_addr;
      wdata_log[k] = bram_wr_data;
      raddr_log[k] = bram_rd_addr;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_sweep(input string tag);
    logic [54:0] m;
    logic [63:0] w;
    logic [3:0]  exp_addr;
    logic        any_ovf, exp_wea;
    int          idx, ent;
    any_ovf = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      exp_wea = (k >= 6) && (k < 6 + 16);
      checks++;
      if (wea_log[k] !== exp_wea) begin
        failures++;
        $display("FAIL %s wea cycle %0d: got %b want %b", tag, k, wea_log[k], exp_wea);
      end
      checks++;
      if (busy_log[k] !== (k < 22)) begin
        failures++;
        $display("FAIL %s busy cycle %0d: got %b want %b", tag, k, busy_log[k], (k < 22));
      end
      checks++;
      if (done_log[k] !== (k == 22)) begin
        failures++;
        $display("FAIL %s done cycle %0d: got %b want %b", tag, k, done_log[k], (k == 22));
      end
      if (k % 2 == 0 && k < 16) begin
        checks++;
        if (raddr_log[k] !== 3'(k / 2)) begin
          failures++;
          $display("FAIL %s rd_addr cycle %0d: got %0d want %0d", tag, k, raddr_log[k], k / 2);
        end
      end
      if (exp_wea) begin
        idx      = k - 6;
        ent      = idx / 2;
        w        = (idx % 2 == 1) ? mem[ent][63:0] : mem[ent][127:64];
        exp_addr = (idx % 2 == 1) ? 4'(8 + ent) : 4'(ent);
        m        = model_conv(w, int'(scale_power), q);
        any_ovf  = any_ovf | m[54];
        checks++;
        if (waddr_log[k] !== exp_addr) begin
          failures++;
          $display("FAIL %s wr_addr cycle %0d: got %0d want %0d", tag, k, waddr_log[k], exp_addr);
        end
        checks++;
        if (wdata_log[k] !== m[53:0]) begin
          failures++;
          $display("FAIL %s wr_data addr %0d word %h: got %h want %h", tag, exp_addr, w, wdata_log[k], m[53:0]);
        end
      end
    end
    checks++;
    if (ovf_log[NCYC-1] !== any_ovf) begin
      failures++;
      $display("FAIL %s overflow after done: got %b want %b", tag, ovf_log[NCYC-1], any_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bram_wea, overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset flags: got %b want 0000", {busy, done, bram_wea, overflow});
    end
    checks++;
    if (bram_rd_addr !== 3'd0 || bram_wr_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset addr: got rd %0d wr %0d want 0 0", bram_rd_addr, bram_wr_addr);
    end
    checks++;
    if (bram_wr_data !== 54'd0) begin
      failures++;
      $display("FAIL reset wr_data: got %h want 0", bram_wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_scale();
    q = Q_STD;
    scale_power = 12'd10;
    fill_random(1'b0);
    mem[0] = {F_ONE, F_MONE};
    run_sweep(-1, 1'b1);
    check_sweep("scale");
    checks++;
    if (wdata_log[6] !== 54'd1024) begin
      failures++;
      $display("FAIL scale addr0: got %0d want 1024", wdata_log[6]);
    end
    checks++;
    if (wdata_log[7] !== Q_STD - 54'd1024 || waddr_log[7] !== 4'd8) begin
      failures++;
      $display("FAIL scale addr8: got %0d at %0d want %0d at 8", wdata_log[7], waddr_log[7], Q_STD - 54'd1024);
    end
  endtask

  task automatic test_rounding();
    q = Q_STD;
    scale_power = 12'd0;
    fill_random(1'b0);
    mem[0] = {F_ONE, F_MONE};
    mem[1] = {F_HALF, F_MHALF};
    mem[2] = {F_PZ, F_TINY};
    mem[3] = {F_BIG, F_1P5};
    mem[4] = {F_QTR, F_NZ};
    run_sweep(-1, 1'b0);
    check_sweep("round");
    checks++;
    if (wdata_log[8] !== 54'd1 || wdata_log[9] !== Q_STD - 54'd1) begin
      failures++;
      $display("FAIL round half: got %0d %0d want 1 %0d", wdata_log[8], wdata_log[9], Q_STD - 54'd1);
    end
    checks++;
    if (wdata_log[10] !== 54'd0 || wdata_log[11] !== 54'd0 || ovf_log[11] !== 1'b0) begin
      failures++;
      $display("FAIL round zero_tiny: got %0d %0d ovf %b want 0 0 ovf 0", wdata_log[10], wdata_log[11], ovf_log[11]);
    end
    checks++;
    if (wdata_log[12] !== 54'd0 || ovf_log[12] !== 1'b1) begin
      failures++;
      $display("FAIL round big: got %0d ovf %b want 0 ovf 1", wdata_log[12], ovf_log[12]);
    end
    checks++;
    if (wdata_log[13] !== 54'd2 || wdata_log[14] !== 54'd0 || wdata_log[15] !== 54'd0) begin
      failures++;
      $display("FAIL round 1p5_qtr_negzero: got %0d %0d %0d want 2 0 0", wdata_log[13], wdata_log[14], wdata_log[15]);
    end
  endtask

  task automatic test_overflow_clear();
    q = Q_STD;
    scale_power = 12'($urandom_range(0, 8));
    fill_random(1'b0);
    run_sweep(-1, 1'b0);
    check_sweep("ovf_clear");
    checks++;
    if (ovf_log[0] !== 1'b0 || ovf_log[NCYC-1] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got start %b end %b want 0 0", ovf_log[0], ovf_log[NCYC-1]);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 5; s++) begin
      q = 54'({$urandom, $urandom}) | 54'd1;
      if (s == 0) q = Q_STD;
      scale_power = 12'($urandom_range(0, 60));
      fill_random(1'b1);
      run_sweep(-1, 1'b0);
      check_sweep($sformatf("random%0d", s));
    end
  endtask

  task automatic test_reset_mid();
    q = Q_STD;
    scale_power = 12'd4;
    fill_random(1'b0);
    run_sweep(10, 1'b0);
    for (int k = 0; k < NCYC; k++) begin
      checks++;
      if (wea_log[k] !== (k >= 6 && k <= 10)) begin
        failures++;
        $display("FAIL abort wea cycle %0d: got %b want %b", k, wea_log[k], (k >= 6 && k <= 10));
      end
      checks++;
      if (busy_log[k] !== (k <= 10) || done_log[k] !== 1'b0) begin
        failures++;
        $display("FAIL abort busy_done cycle %0d: got %b%b want %b0", k, busy_log[k], done_log[k], (k <= 10));
      end
    end
    fill_random(1'b0);
    run_sweep(-1, 1'b0);
    check_sweep("after_abort");
  endtask

  task automatic test_rst_with_start();
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || bram_wea !== 1'b0) begin
        failures++;
        $display("FAIL rst_start cycle %0d: got busy %b wea %b want 0 0", i, busy, bram_wea);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    q = Q_STD;
    scale_power = 12'd0;
    for (int i = 0; i < NE; i++) mem[i] = 128'd0;
    test_reset();
    test_scale();
    test_rounding();
    test_overflow_clear();
    test_random();
    test_reset_mid();
    test_rst_with_start();
    test_overflow_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
